// File: rtl/clkdiv_pkg.sv
// Purpose : shared types and phase arithmetic for the clock-divider configuration sequencer.
// Latency : n/a (types, constants and pure functions only).
// Backpressure: n/a.
package clkdiv_pkg;

    // Reprogram sequencer states (3-bit encoding).
    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_ALIGN       = 3'd1,
        ST_HOLD        = 3'd2,
        ST_LOAD        = 3'd3,
        ST_RESTART     = 3'd4,
        ST_WAIT_STABLE = 3'd5
    } state_t;

    // Output 0 always rises at counter==0; the sequencer relies on this to
    // treat the divider's clkrise0 as a "counter is zero" indication.
    localparam logic [7:0] PHASE_RISE0 = 8'd0;

    // Base phase word {fall, rise} for divide word div (period = div+1).
    // 9-bit arithmetic so div=255 (N=256) does not wrap before the shift.
    function automatic logic [15:0] phase_calc(input logic [7:0] div);
        logic [8:0] n;
        logic [8:0] half;
        n    = {1'b0, div} + 9'd1;
        half = n >> 1;
        return {half[7:0], PHASE_RISE0};
    endfunction

    // Quadrature phase word: rise at N/4, fall half a period later.
    function automatic logic [15:0] phase90_calc(input logic [7:0] div);
        logic [8:0] n;
        logic [8:0] rise;
        logic [8:0] fall;
        n    = {1'b0, div} + 9'd1;
        rise = n >> 2;
        fall = rise + (n >> 1);
        return {fall[7:0], rise[7:0]};
    endfunction

endpackage

// File: rtl/clkdiv_ctrl_if.sv
// Purpose : configuration request/status bundle between the CSR layer and clkdiv_ctrl.
// Latency : n/a (wiring only).
// Backpressure: cfg_ready low holds off the requester while a reprogram is in flight.
//   cfg_valid/cfg_ready/cfg_div : request handshake and requested divide word
//   busy/done/err_timeout       : sequencer status back to the CSR layer
interface clkdiv_ctrl_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_div;
    logic       busy;
    logic       done;
    logic       err_timeout;

    modport master (
        output cfg_valid, cfg_div,
        input  cfg_ready, busy, done, err_timeout
    );

    modport slave (
        input  cfg_valid, cfg_div,
        output cfg_ready, busy, done, err_timeout
    );
endinterface

// File: rtl/clkdiv_phase_calc.sv
// Purpose : derive rise/fall phase words for both divider outputs from a divide word.
// Latency : combinational.
// Backpressure: none.
//   cfg_div -> phase0 ([7:0] rise, [15:8] fall), phase1 (same layout)
//   CLKDIV_CTRL_PHASE90_EN defined: phase1 is the 90-degree shifted copy;
//   undefined: phase1 mirrors phase0.
module clkdiv_phase_calc
    import clkdiv_pkg::*;
(
    input  logic [7:0]  cfg_div,
    output logic [15:0] phase0,
    output logic [15:0] phase1
);

    assign phase0 = phase_calc(cfg_div);

`ifdef CLKDIV_CTRL_PHASE90_EN
    assign phase1 = phase90_calc(cfg_div);
`else
    assign phase1 = phase_calc(cfg_div);
`endif

endmodule

// File: rtl/clkdiv_ctrl.sv
// Purpose : glitch-safe reprogram sequencer for the clock divider (align, freeze, load, restart, wait stable).
// Latency : accept -> done >= 4 cycles + divider settle time; each wait state bounded by TIMEOUT cycles.
// Backpressure: cfg_ready only in IDLE; requests presented while busy are not taken.
//   clk, nreset            : clock, async active-low reset
//   cfg (clkdiv_ctrl_if)   : request handshake + busy/done/err_timeout status
//   clkrise0_in            : divider counter==0 indication
//   clkstable_in           : divider output stable flag
//   clken/clkchange        : divider enable and one-cycle parameter-change pulse
//   clkdiv/clkphase0/1     : registered divide word and phase words
// Optional: CLKDIV_CTRL_PHASE90_EN (inside clkdiv_phase_calc) makes clkphase1 quadrature.
module clkdiv_ctrl
    import clkdiv_pkg::*;
#(
    parameter logic [7:0] RESET_DIV = 8'd1,
    parameter int          TIMEOUT   = 4095,
    parameter int          TW        = 12
) (
    input  logic                clk,
    input  logic                nreset,
    clkdiv_ctrl_if.slave        cfg,
    input  logic                clkrise0_in,
    input  logic                clkstable_in,
    output logic                clken,
    output logic                clkchange,
    output logic [7:0]          clkdiv,
    output logic [15:0]         clkphase0,
    output logic [15:0]         clkphase1
);

    // Counter value on the last permitted cycle of a wait state.
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_t          state;
    logic [7:0]      div_req;
    logic [TW-1:0]   tmo_cnt;
    logic            done_q;
    logic            err_q;
    logic            chg_q;

    logic [15:0]     new_phase0;
    logic [15:0]     new_phase1;
    logic [15:0]     rst_phase0;
    logic [15:0]     rst_phase1;

    // Phase words for the pending request.
    clkdiv_phase_calc u_req_calc (
        .cfg_div (div_req),
        .phase0  (new_phase0),
        .phase1  (new_phase1)
    );

    // Constant-input instance: folds to the reset values of the phase registers.
    clkdiv_phase_calc u_rst_calc (
        .cfg_div (RESET_DIV),
        .phase0  (rst_phase0),
        .phase1  (rst_phase1)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= ST_IDLE;
            div_req   <= RESET_DIV;
            tmo_cnt   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            chg_q     <= 1'b0;
            clkdiv    <= RESET_DIV;
            clkphase0 <= rst_phase0;
            clkphase1 <= rst_phase1;
        end else begin
            done_q <= 1'b0;
            chg_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cfg.cfg_valid) begin
                        div_req <= cfg.cfg_div;
                        err_q   <= 1'b0;
                        tmo_cnt <= '0;
                        state   <= ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    // A hit on the last allowed cycle still wins over timeout.
                    if (clkrise0_in) begin
                        state <= ST_HOLD;
                    end else if (tmo_cnt == TMO_LAST) begin
                        err_q <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                ST_HOLD: begin
                    chg_q <= 1'b1;   // registered so the pulse lines up with LOAD
                    state <= ST_LOAD;
                end
                ST_LOAD: begin
                    clkdiv    <= div_req;
                    clkphase0 <= new_phase0;
                    clkphase1 <= new_phase1;
                    state     <= ST_RESTART;
                end
                ST_RESTART: begin
                    // clkstable_in is not looked at here: the divider has only
                    // just seen clkchange, so its flag may still be the old one.
                    tmo_cnt <= '0;
                    state   <= ST_WAIT_STABLE;
                end
                ST_WAIT_STABLE: begin
                    if (clkstable_in) begin
                        done_q <= 1'b1;
                        state  <= ST_IDLE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        err_q <= 1'b1;   // new settings remain loaded
                        state <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Enable drops in the same cycle the counter is seen at zero, so the
    // divider freezes at 0; it stays low through HOLD and LOAD (3 cycles).
    assign clken = !((state == ST_ALIGN && clkrise0_in) ||
                     state == ST_HOLD || state == ST_LOAD);

    assign clkchange       = chg_q;
    assign cfg.cfg_ready   = (state == ST_IDLE);
    assign cfg.busy        = (state != ST_IDLE);
    assign cfg.done        = done_q;
    assign cfg.err_timeout = err_q;

endmodule
